// File: rtl/ddr_pkg.sv
// ddr_pkg: lane enum, playfield constants and small distance helpers shared
// by the arrow engine and its per-lane slot arrays.
package ddr_pkg;

  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    UP    = 2'd1,
    RIGHT = 2'd2,
    DOWN  = 2'd3
  } lane_e;

  localparam logic [9:0] Y_SPAWN   = 10'd440;
  localparam logic [9:0] Y_TARGET  = 10'd40;
  localparam logic [3:0] SCORE_MAX = 4'd10;

  // |a - b| computed as an 11-bit signed difference so nothing wraps.
  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[10] ? $unsigned(-d) : $unsigned(d);
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/arrow_lane_engine_if.sv
// arrow_lane_engine_if: spawn handshake, frame step, buttons and the
// judgement results (hit/miss/score). The pixel path stays on plain ports.
interface arrow_lane_engine_if;
  logic       step;
  logic       spawn_valid;
  logic [1:0] spawn_lane;
  logic       spawn_ready;
  logic [3:0] btn;
  logic [3:0] hit;
  logic [3:0] miss;
  logic [3:0] score;

  modport master (
    output step, spawn_valid, spawn_lane, btn,
    input  spawn_ready, hit, miss, score
  );

  modport slave (
    input  step, spawn_valid, spawn_lane, btn,
    output spawn_ready, hit, miss, score
  );
endinterface

// File: rtl/arrow_lane.sv
// arrow_lane: one lane's arrow slots. Allocates spawns into the lowest free
// slot, scrolls/expires arrows on step, searches for a hit on a button press
// and reports whether any arrow or the target box covers the current pixel.
// Optional build macro: ARROW_MISS_PENALTY_EN (unmatched press flags a penalty).
module arrow_lane
  import ddr_pkg::*;
#(
  parameter int         SLOTS      = 4,
  parameter int         SPEED      = 2,
  parameter int         HALF       = 10,
  parameter int         HIT_WINDOW = 10,
  parameter logic [9:0] LANE_X     = 10'd200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       step,
  input  logic       spawn_en,
  input  logic       btn,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic       spawn_free,
  output logic       hit_now,
  output logic       miss_now,
  output logic       penalty_now,
  output logic       arrow_ovl,
  output logic       target_ovl
);

  localparam int          IW       = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [9:0]  EXPIRE_Y = 10'(int'(Y_TARGET) - HIT_WINDOW + SPEED);
  localparam logic [10:0] WIN      = 11'(HIT_WINDOW);
  localparam logic [10:0] HALF_W   = 11'(HALF);
  localparam logic [9:0]  SPEED_W  = 10'(SPEED);

  logic [SLOTS-1:0] valid_q, valid_d;
  logic [9:0]       y_q [SLOTS];
  logic [9:0]       y_d [SLOTS];
  logic             free_found;
  logic [IW-1:0]    free_idx;
  logic             hit_found;
  logic [IW-1:0]    hit_idx;
  logic [10:0]      tdx, tdy;

  // Lowest free slot, judged only from the valid bits held before this cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  // Lowest live slot within the hit window of the target row on a press.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (btn && valid_q[i] && (abs_diff(y_q[i], Y_TARGET) <= WIN)) begin
        hit_found = 1'b1;
        hit_idx   = IW'(i);
      end
    end
  end

  assign spawn_free = free_found;
  assign hit_now    = hit_found;

`ifdef ARROW_MISS_PENALTY_EN
  assign penalty_now = btn & ~hit_found;
`else
  assign penalty_now = 1'b0;
`endif

  // Slot update: a hit clears its slot ahead of any step; step scrolls or
  // expires the rest; a spawn lands in a slot that was free before the cycle.
  always_comb begin
    valid_d  = valid_q;
    miss_now = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      y_d[i] = y_q[i];
      if (valid_q[i]) begin
        if (hit_found && (hit_idx == IW'(i))) begin
          valid_d[i] = 1'b0;
        end else if (step) begin
          if (y_q[i] < EXPIRE_Y) begin
            valid_d[i] = 1'b0;
            miss_now   = 1'b1;
          end else begin
            y_d[i] = y_q[i] - SPEED_W;
          end
        end
      end
    end
    if (spawn_en && free_found) begin
      valid_d[free_idx] = 1'b1;
      y_d[free_idx]     = Y_SPAWN;
    end
  end

  // Does any live arrow sprite of this lane cover the current pixel?
  always_comb begin
    arrow_ovl = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (valid_q[i] && (abs_diff(pix_x, LANE_X) <= HALF_W) &&
          (abs_diff(pix_y, y_q[i]) <= HALF_W)) begin
        arrow_ovl = 1'b1;
      end
    end
  end

  assign tdx        = abs_diff(pix_x, LANE_X);
  assign tdy        = abs_diff(pix_y, Y_TARGET);
  assign target_ovl = (tdx <= HALF_W) && (tdy <= HALF_W) &&
                      ((tdx == HALF_W) || (tdy == HALF_W));

  // Slot registers; reset discards every arrow at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < SLOTS; i++) y_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < SLOTS; i++) y_q[i] <= y_d[i];
    end
  end

endmodule

// File: rtl/arrow_lane_engine.sv
// arrow_lane_engine: four-lane DDR arrow engine. Instantiates one arrow_lane
// per lane, merges their pixel terms into registered arrow/target bits and
// keeps the registered hit/miss pulses and the saturating score.
// Optional build macro: ARROW_MISS_PENALTY_EN (unmatched press costs a point).
module arrow_lane_engine
  import ddr_pkg::*;
#(
  parameter int SLOTS      = 4,
  parameter int SPEED      = 2,
  parameter int HALF       = 10,
  parameter int HIT_WINDOW = 10,
  parameter int COL_X0     = 200,
  parameter int COL_PITCH  = 80
) (
  input  logic                clk,
  input  logic                reset_n,
  arrow_lane_engine_if.slave  bus,
  input  logic [9:0]          CounterX,
  input  logic [9:0]          CounterY,
  input  logic                inDisplayArea,
  output logic                arrow_pix,
  output logic                target_pix
);

  logic [3:0] lane_free, hit_now, miss_now, penalty_now, arrow_ovl, target_ovl;
  logic [3:0] hit_q, hit_d, miss_q, miss_d, score_q, score_d;
  logic [4:0] score_sum, score_pen;
  logic       arrow_pix_q, arrow_pix_d, target_pix_q, target_pix_d;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    arrow_lane #(
      .SLOTS      (SLOTS),
      .SPEED      (SPEED),
      .HALF       (HALF),
      .HIT_WINDOW (HIT_WINDOW),
      .LANE_X     (10'(COL_X0 + l * COL_PITCH))
    ) u_lane (
      .clk         (clk),
      .reset_n     (reset_n),
      .step        (bus.step),
      .spawn_en    (bus.spawn_valid && (bus.spawn_lane == 2'(l))),
      .btn         (bus.btn[l]),
      .pix_x       (CounterX),
      .pix_y       (CounterY),
      .spawn_free  (lane_free[l]),
      .hit_now     (hit_now[l]),
      .miss_now    (miss_now[l]),
      .penalty_now (penalty_now[l]),
      .arrow_ovl   (arrow_ovl[l]),
      .target_ovl  (target_ovl[l])
    );
  end

  assign bus.spawn_ready = lane_free[bus.spawn_lane];

  // Next pulses, score (hits saturate first, penalties then floor at zero)
  // and the merged pixel bits qualified by the visible area.
  always_comb begin
    hit_d     = hit_now;
    miss_d    = miss_now | penalty_now;
    score_sum = 5'(score_q) + 5'(popcount4(hit_now));
    if (score_sum > 5'(SCORE_MAX)) score_sum = 5'(SCORE_MAX);
    score_pen = 5'(popcount4(penalty_now));
    score_d   = (score_sum > score_pen) ? 4'(score_sum - score_pen) : 4'd0;
    arrow_pix_d  = inDisplayArea & (|arrow_ovl);
    target_pix_d = inDisplayArea & (|target_ovl);
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q        <= '0;
      miss_q       <= '0;
      score_q      <= '0;
      arrow_pix_q  <= 1'b0;
      target_pix_q <= 1'b0;
    end else begin
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      score_q      <= score_d;
      arrow_pix_q  <= arrow_pix_d;
      target_pix_q <= target_pix_d;
    end
  end

  assign bus.hit    = hit_q;
  assign bus.miss   = miss_q;
  assign bus.score  = score_q;
  assign arrow_pix  = arrow_pix_q;
  assign target_pix = target_pix_q;

endmodule

// File: tb/tb_arrow_lane_engine.sv
// tb_arrow_lane_engine: directed scenarios plus randomized traffic against a
// slot-level reference model; expected hit/miss/score events and pixel bits
// are queued at stimulus time and consumed by an independent monitor.
module tb_arrow_lane_engine;

  localparam int SLOTS = 4, SPEED = 2, HALF = 10, HIT_WINDOW = 10;
  localparam int COL_X0 = 200, COL_PITCH = 80;
  localparam int YS = 440, YT = 40, SMAX = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] CounterX, CounterY;
  logic       inDisplayArea;
  logic       arrow_pix, target_pix;

  arrow_lane_engine_if bus();

  arrow_lane_engine #(
    .SLOTS(SLOTS), .SPEED(SPEED), .HALF(HALF), .HIT_WINDOW(HIT_WINDOW),
    .COL_X0(COL_X0), .COL_PITCH(COL_PITCH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .CounterX(CounterX), .CounterY(CounterY), .inDisplayArea(inDisplayArea),
    .arrow_pix(arrow_pix), .target_pix(target_pix)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [3:0] hit; logic [3:0] miss; int score; } ev_t;
  typedef struct { int cyc; logic a; logic t; } px_t;
  ev_t ev_q[$];
  px_t px_q[$];

  // reference model: per-lane slots with arrow heights, plus the score
  int m_valid [4][SLOTS];
  int m_y     [4][SLOTS];
  int m_score;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void checkOutput(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int lane_x(int l);
    return COL_X0 + l * COL_PITCH;
  endfunction

  function automatic int clamp10(int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  function automatic int lane_count(int l);
    int n = 0;
    for (int s = 0; s < SLOTS; s++) n += m_valid[l][s];
    return n;
  endfunction

  function automatic void model_clear();
    for (int l = 0; l < 4; l++)
      for (int s = 0; s < SLOTS; s++) begin
        m_valid[l][s] = 0;
        m_y[l][s]     = 0;
      end
    m_score = 0;
  endfunction

  function automatic void model_pixel(input int x, input int y, input logic de,
                                      output logic a, output logic t);
    a = 1'b0;
    t = 1'b0;
    for (int l = 0; l < 4; l++) begin
      int dx = iabs(x - lane_x(l));
      int dy = iabs(y - YT);
      for (int s = 0; s < SLOTS; s++)
        if (m_valid[l][s] != 0 && dx <= HALF && iabs(y - m_y[l][s]) <= HALF) a = 1'b1;
      if (dx <= HALF && dy <= HALF && (dx == HALF || dy == HALF)) t = 1'b1;
    end
    a = a & de;
    t = t & de;
  endfunction

  // One clock of game rules applied to the model state.
  function automatic void model_cycle(logic st, logic spawn_ok, int sl, logic [3:0] b);
    logic [3:0] hv = '0, mv = '0, pv = '0;
    int hs[4];
    int sp = -1;
    for (int l = 0; l < 4; l++) begin
      hs[l] = -1;
      if (b[l]) begin
        for (int s = 0; s < SLOTS; s++)
          if (hs[l] < 0 && m_valid[l][s] != 0 && iabs(m_y[l][s] - YT) <= HIT_WINDOW) hs[l] = s;
        if (hs[l] >= 0) hv[l] = 1'b1;
        else pv[l] = 1'b1;
      end
    end
    if (spawn_ok)
      for (int s = SLOTS - 1; s >= 0; s--) if (m_valid[sl][s] == 0) sp = s;
    for (int l = 0; l < 4; l++)
      for (int s = 0; s < SLOTS; s++)
        if (m_valid[l][s] != 0 && s != hs[l] && st) begin
          if (m_y[l][s] - SPEED < YT - HIT_WINDOW) begin
            m_valid[l][s] = 0;
            mv[l] = 1'b1;
          end else m_y[l][s] -= SPEED;
        end
    for (int l = 0; l < 4; l++) if (hs[l] >= 0) m_valid[l][hs[l]] = 0;
    if (sp >= 0) begin
      m_valid[sl][sp] = 1;
      m_y[sl][sp]     = YS;
    end
    m_score += $countones(hv);
    if (m_score > SMAX) m_score = SMAX;
`ifdef ARROW_MISS_PENALTY_EN
    m_score -= $countones(pv);
    if (m_score < 0) m_score = 0;
    mv = mv | pv;
`endif
    if ((hv | mv) != 4'b0) ev_q.push_back('{cyc + 1, hv, mv, m_score});
  endfunction

  task automatic applyStimulus(input logic st, input logic sv, input int sl, input logic [3:0] b,
                               input int px, input int py, input logic de);
    logic exp_a, exp_t, ready;
    @(negedge clk);
    bus.step        = st;
    bus.spawn_valid = sv;
    bus.spawn_lane  = 2'(sl);
    bus.btn         = b;
    CounterX        = 10'(clamp10(px));
    CounterY        = 10'(clamp10(py));
    inDisplayArea   = de;
    model_pixel(int'(CounterX), int'(CounterY), de, exp_a, exp_t);
    px_q.push_back('{cyc + 1, exp_a, exp_t});
    ready = (lane_count(sl) < SLOTS);
    #1;
    checkOutput("spawn_ready", int'(bus.spawn_ready), int'(ready));
    model_cycle(st, sv && ready, sl, b);
  endtask

  task automatic randPixel(output int px, output int py);
    int pl = $urandom_range(0, 3);
    int ps = $urandom_range(0, SLOTS - 1);
    px = lane_x(pl) + int'($urandom_range(0, 30)) - 15;
    if ($urandom_range(0, 5) == 0) py = YT + int'($urandom_range(0, 24)) - 12;
    else if (m_valid[pl][ps] != 0) py = m_y[pl][ps] + int'($urandom_range(0, 24)) - 12;
    else py = $urandom_range(0, 479);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 0, 4'b0, 0, 0, 1'b0);
  endtask

  task automatic spawn(input int l);
    applyStimulus(1'b0, 1'b1, l, 4'b0, 0, 0, 1'b0);
  endtask

  task automatic press(input logic st, input logic [3:0] b);
    applyStimulus(st, 1'b0, 0, b, 0, 0, 1'b0);
  endtask

  task automatic stepN(input int n);
    int px, py;
    for (int k = 0; k < n; k++) begin
      randPixel(px, py);
      applyStimulus(1'b1, 1'b0, 0, 4'b0, px, py, 1'b1);
    end
  endtask

  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.step = 1'b0; bus.spawn_valid = 1'b0; bus.spawn_lane = 2'd0; bus.btn = 4'b0;
    CounterX = 10'd0; CounterY = 10'd0; inDisplayArea = 1'b0;
    model_clear();
    ev_q.delete();
    px_q.delete();
    #1;
    checkOutput("reset_hit", int'(bus.hit), 0);
    checkOutput("reset_miss", int'(bus.miss), 0);
    checkOutput("reset_score", int'(bus.score), 0);
    checkOutput("reset_arrow_pix", int'(arrow_pix), 0);
    checkOutput("reset_target_pix", int'(target_pix), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int l = 0; l < 4; l++) begin
      bus.spawn_lane = 2'(l);
      #1;
      checkOutput("post_reset_spawn_ready", int'(bus.spawn_ready), 1);
    end
  endtask

  // Monitor: consumes queued expectations whenever the DUT shows a pulse.
  always @(posedge clk) begin
    ev_t e;
    px_t p;
    #1;
    if (reset_n) begin
      while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
        e = ev_q.pop_front();
        n_checks++;
        $display("[TB] FAIL missing_event: cycle %0d got none, expected hit=%b miss=%b",
                 e.cyc, e.hit, e.miss);
      end
      if (bus.hit != 4'b0 || bus.miss != 4'b0) begin
        if (ev_q.size() == 0) begin
          checkOutput("unexpected_event", int'({bus.hit, bus.miss}), 0);
        end else begin
          e = ev_q.pop_front();
          checkOutput("event_cycle", cyc, e.cyc);
          checkOutput("hit", int'(bus.hit), int'(e.hit));
          checkOutput("miss", int'(bus.miss), int'(e.miss));
          checkOutput("score", int'(bus.score), e.score);
        end
      end
      while (px_q.size() > 0 && px_q[0].cyc <= cyc) begin
        p = px_q.pop_front();
        if (p.cyc == cyc) begin
          checkOutput("arrow_pix", int'(arrow_pix), int'(p.a));
          checkOutput("target_pix", int'(target_pix), int'(p.t));
        end else begin
          checkOutput("pixel_sample_lost", p.cyc, cyc);
        end
      end
    end
  end

  initial begin
    bus.step = 1'b0; bus.spawn_valid = 1'b0; bus.spawn_lane = 2'd0; bus.btn = 4'b0;
    CounterX = 10'd0; CounterY = 10'd0; inDisplayArea = 1'b0;
    model_clear();

    applyReset();

    // hit exactly on the target row
    spawn(0);
    stepN(200);
    press(1'b0, 4'b0001);
    waitEdge();
    checkOutput("score_after_first_hit", int'(bus.score), 1);

    // lane 3 expires on the 206th step
    spawn(3);
    stepN(206);
    waitEdge();
    checkOutput("score_after_expiry", int'(bus.score), 1);

    // lane 2 fills up, a fifth request is refused, one hit frees a slot
    for (int k = 0; k < 5; k++) spawn(2);
    stepN(200);
    press(1'b0, 4'b0100);
    idle();
    bus.spawn_lane = 2'd2;
    #1;
    checkOutput("lane2_ready_after_hit", int'(bus.spawn_ready), 1);
    stepN(6);

    // build the score to 8, then hit all four lanes together with a step
    for (int l = 0; l < 4; l++) spawn(l);
    stepN(200);
    press(1'b0, 4'b1111);
    for (int l = 0; l < 4; l++) spawn(l);
    spawn(0);
    spawn(1);
    stepN(200);
    press(1'b0, 4'b0011);
    waitEdge();
    checkOutput("score_before_saturation", int'(bus.score), 8);
    press(1'b1, 4'b1111);
    waitEdge();
    checkOutput("score_saturated", int'(bus.score), 10);

    // arrow at y=30 pressed together with a step: hit wins over expiry
    spawn(3);
    stepN(205);
    press(1'b1, 4'b1000);
    waitEdge();
    checkOutput("score_stays_saturated", int'(bus.score), 10);

    // pixel overlap and target outline probes
    spawn(1);
    applyStimulus(1'b0, 1'b0, 0, 4'b0, 285, 445, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 4'b0, 291, 445, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 4'b0, 285, 445, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 4'b0, 190, 30, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 4'b0, 200, 40, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 4'b0, 365, 50, 1'b1);
    waitEdge();
    checkOutput("arrow_pix_lane1_direct", int'(arrow_pix), 0);

    // reset while an arrow is in flight
    spawn(0);
    stepN(3);
    applyReset();
    waitEdge();
    checkOutput("score_after_midflight_reset", int'(bus.score), 0);

`ifdef ARROW_MISS_PENALTY_EN
    spawn(0);
    stepN(200);
    press(1'b0, 4'b0001);
    press(1'b0, 4'b1000);
    waitEdge();
    checkOutput("penalty_score_zero", int'(bus.score), 0);
    press(1'b0, 4'b1000);
    waitEdge();
    checkOutput("penalty_score_floor", int'(bus.score), 0);
`endif

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      logic st, sv;
      logic [3:0] b;
      int sl, px, py;
      st = ($urandom_range(0, 1) == 1);
      sv = ($urandom_range(0, 2) == 0);
      sl = $urandom_range(0, 3);
      for (int j = 0; j < 4; j++) b[j] = ($urandom_range(0, 7) == 0);
      randPixel(px, py);
      applyStimulus(st, sv, sl, b, px, py, ($urandom_range(0, 9) != 0));
    end

    idle();
    repeat (3) waitEdge();
    while (ev_q.size() > 0) begin
      ev_t e;
      e = ev_q.pop_front();
      n_checks++;
      $display("[TB] FAIL missing_event_at_end: cycle %0d expected hit=%b miss=%b",
               e.cyc, e.hit, e.miss);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
